// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B3 arbiter with round-robin grant held
// for a whole cyc and a bus watchdog that turns a hung slave into err.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    // master 0
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic [2:0]      m0_cti_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic [2:0]      m1_cti_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic [2:0]      s_cti_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    // status
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;   // last master served: 0 = m0, 1 = m1
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wd_fire;

    // State, round-robin pointer and watchdog counter registers
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate only from IDLE, hold grant until cyc drops
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                    last_d  = ~last_q;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wd_fire = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT));

    // Watchdog: count unanswered strobe cycles, clear on any response or fire
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && s_stb_o && !s_ack_i && !s_err_i)
            cnt_d = cnt_q + CW'(1);
    end

    // Data/control mux driven purely from the registered grant
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cti_o   = 3'b000;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;
        case (state_q)
            GNT0: begin
                grant_o   = 2'b01;
                timeout_o = wd_fire;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_cti_o   = m0_cti_i;
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i & ~wd_fire;
                m0_dat_o  = s_dat_i;
                m0_ack_o  = s_ack_i & m0_stb_i;
                m0_err_o  = (s_err_i & m0_stb_i) | wd_fire;
            end
            GNT1: begin
                grant_o   = 2'b10;
                timeout_o = wd_fire;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_cti_o   = m1_cti_i;
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i & ~wd_fire;
                m1_dat_o  = s_dat_i;
                m1_ack_o  = s_ack_i & m1_stb_i;
                m1_err_o  = (s_err_i & m1_stb_i) | wd_fire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m (TIMEOUT = 8).
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            nrst_i;
    logic [AW-1:0]   m0_adr_i, m1_adr_i;
    logic [DW-1:0]   m0_dat_i, m1_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic            m0_we_i, m1_we_i;
    logic [2:0]      m0_cti_i, m1_cti_i;
    logic            m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o;
    logic [2:0]      s_cti_o;
    logic            s_cyc_o, s_stb_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic [1:0]      grant_o;
    logic            timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // advance one clock; inputs are then driven 1 time unit after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        nrst_i   = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0A00;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0B00;
        s_ack_i  = 1'b1; s_err_i = 1'b1; s_dat_i = 32'h1234_5678;
        tick(); tick();
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: grant=%b cyc=%b stb=%b to=%b, want 00 0 0 0", grant_o, s_cyc_o, s_stb_o, timeout_o);
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0 || m0_dat_o !== '0 || m1_dat_o !== '0 || s_adr_o !== '0) begin
            errors++;
            $display("FAIL reset_resp: acks/errs=%b m0dat=%h m1dat=%h adr=%h, want all 0",
                     {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, m0_dat_o, m1_dat_o, s_adr_o);
        end
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        nrst_i = 1'b1;
        tick(); #1;
        checks++;
        if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_0A00) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b cyc=%b adr=%h, want 01 1 00000a00", grant_o, s_cyc_o, s_adr_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); #1;
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: grant=%b want 00", grant_o);
        end
    endtask

    task automatic test_single_read();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h10; m1_we_i = 1'b0; m1_sel_i = 4'hF;
        tick(); #1;
        checks++;
        if (grant_o !== 2'b10 || s_adr_o !== 32'h10 || s_stb_o !== 1'b1 || s_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL read_grant: grant=%b adr=%h stb=%b sel=%h, want 10 10 1 f", grant_o, s_adr_o, s_stb_o, s_sel_o);
        end
        tick(); #1;  // second wait state
        checks++;
        if (m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL read_wait: m1_ack=%b want 0", m1_ack_o);
        end
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m1_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m0_dat_o !== '0) begin
            errors++;
            $display("FAIL read_ack: m1dat=%h m1ack=%b m0ack=%b m0dat=%h, want deadbeef 1 0 0",
                     m1_dat_o, m1_ack_o, m0_ack_o, m0_dat_o);
        end
        tick();
        s_ack_i = 1'b0; s_dat_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b10) begin
            errors++;
            $display("FAIL read_release: s_cyc=%b grant=%b, want 0 10", s_cyc_o, grant_o);
        end
        tick(); #1;
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL read_idle: grant=%b want 00", grant_o);
        end
    endtask

    // last served is m1, so alternation starts with m0
    task automatic test_round_robin();
        logic [1:0] g;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            s_ack_i = 1'b1;
            #1;
            checks++;
            if (grant_o !== g || m0_ack_o !== g[0] || m1_ack_o !== g[1]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: grant=%b acks=%b%b, want %b", i, grant_o, m1_ack_o, m0_ack_o, g);
            end
            tick();
            s_ack_i = 1'b0;
            if (g[0]) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            else      begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            tick(); #1;
            checks++;
            if (grant_o !== 2'b00) begin
                errors++;
                $display("FAIL rr_idle[%0d]: grant=%b want 00", i, grant_o);
            end
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
    endtask

    task automatic test_burst_hold();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010; m0_we_i = 1'b1; m0_dat_i = 32'hCAFE_0000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            if (b == 2) begin  // one-cycle stb gap mid-burst
                m0_stb_i = 1'b0;
                #1;
                checks++;
                if (grant_o !== 2'b01 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_gap: grant=%b stb=%b cyc=%b, want 01 0 1", grant_o, s_stb_o, s_cyc_o);
                end
                tick();
                m0_stb_i = 1'b1;
            end
            s_ack_i = 1'b1;
            #1;
            checks++;
            if (grant_o !== 2'b01 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_cti_o !== 3'b010 || s_we_o !== 1'b1) begin
                errors++;
                $display("FAIL burst_beat[%0d]: grant=%b m0ack=%b m1ack=%b cti=%b we=%b, want 01 1 0 010 1",
                         b, grant_o, m0_ack_o, m1_ack_o, s_cti_o, s_we_o);
            end
        end
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); #1;
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL burst_idle: grant=%b want 00", grant_o);
        end
        tick(); #1;
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("FAIL burst_handover: grant=%b want 10", grant_o);
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_watchdog();
        m0_cti_i = 3'b000;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;  // stb rises in IDLE cycle
        for (int k = 0; k < TO; k++) begin
            tick(); #1;
            checks++;
            if (timeout_o !== 1'b0 || m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
                errors++;
                $display("FAIL wd_early[%0d]: to=%b err=%b stb=%b, want 0 0 1", k, timeout_o, m0_err_o, s_stb_o);
            end
        end
        tick(); #1;  // 9 cycles after stb rose
        checks++;
        if (timeout_o !== 1'b1 || m0_err_o !== 1'b1 || s_stb_o !== 1'b0 || m1_err_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_fire: to=%b m0err=%b stb=%b m1err=%b, want 1 1 0 0", timeout_o, m0_err_o, s_stb_o, m1_err_o);
        end
        tick(); #1;
        checks++;
        if (timeout_o !== 1'b0 || m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL wd_cleared: to=%b err=%b stb=%b, want 0 0 1", timeout_o, m0_err_o, s_stb_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_mid_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010;
        tick();
        s_ack_i = 1'b1;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        checks++;
        if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL mrst_pre: grant=%b cyc=%b, want 10 1", grant_o, s_cyc_o);
        end
        nrst_i = 1'b0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL mrst_async: cyc=%b grant=%b m1ack=%b, want 0 00 0", s_cyc_o, grant_o, m1_ack_o);
        end
        s_ack_i = 1'b0;
        tick();
        nrst_i = 1'b1;
        tick(); #1;
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL mrst_regrant: grant=%b want 01", grant_o);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        m0_dat_i = '0; m1_dat_i = '0; m0_sel_i = '0; m1_sel_i = '0;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_cti_i = '0; m1_cti_i = '0;
        m0_adr_i = '0; m1_adr_i = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_hold();
        test_watchdog();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time bound in case something stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1);
    end

endmodule
